// File: rtl/envelope_detector.sv
// envelope_detector
//   Takes an analytic-signal pair (real, imaginary) and produces the envelope
//   magnitude floor(sqrt(Re^2 + Im^2)) for each accepted sample. A bit-serial
//   integer square root produces one result bit per clock, so each sample
//   occupies the block for DATA_WIDTH+3 cycles.
//
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-high; clears all state and outputs
//   enable       : block enable; gates acceptance of new samples
//   dataInRe     : signed real part
//   dataInIm     : signed imaginary part
//   dataInValid  : a sample is present on dataInRe/dataInIm
//   dataInReady  : block can accept a sample this cycle (combinational)
//   dataOut      : unsigned envelope magnitude, registered and held
//   dataOutValid : one-cycle pulse marking a new dataOut
module envelope_detector #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] dataInRe,
  input  logic signed [DATA_WIDTH-1:0] dataInIm,
  input  logic                         dataInValid,
  output logic                         dataInReady,
  output logic        [DATA_WIDTH-1:0] dataOut,
  output logic                         dataOutValid
);

  localparam int RADW  = 2 * DATA_WIDTH;
  localparam int REMW  = DATA_WIDTH + 2;
  localparam int TRYW  = DATA_WIDTH + 4;
  localparam int CNTW  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    SQRT,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic signed [DATA_WIDTH-1:0] r_re;
  logic signed [DATA_WIDTH-1:0] r_im;
  logic        [RADW-1:0]       r_radicand;
  logic        [DATA_WIDTH-1:0] r_root;
  logic        [REMW-1:0]       r_rem;
  logic        [CNTW-1:0]       r_iter;

  logic signed [RADW-1:0]       w_reSq;
  logic signed [RADW-1:0]       w_imSq;
  logic        [RADW-1:0]       w_sumSq;
  logic        [TRYW-1:0]       w_remShift;
  logic        [TRYW-1:0]       w_trial;
  logic        [REMW-1:0]       w_diff;
  logic                         w_fits;
  logic                         w_accept;

  // Ready is forced low while reset is held even though the state register
  // already reads IDLE, so upstream never sees a phantom accept during reset.
  assign dataInReady = (r_state == IDLE) && enable && !reset;
  assign w_accept    = (r_state == IDLE) && enable && dataInValid;

  // Sum of squares is carried as an unsigned 2*DATA_WIDTH value; the worst
  // case (both parts at the most negative value) is 2^(2*DATA_WIDTH-1),
  // which still fits.
  assign w_reSq  = r_re * r_re;
  assign w_imSq  = r_im * r_im;
  assign w_sumSq = $unsigned(w_reSq) + $unsigned(w_imSq);

  // Restoring square-root step: bring down the next two radicand bits and
  // try subtracting (4*root + 1). The difference is only kept when the trial
  // fits, in which case it is bounded by 2*root and fits in REMW bits, so the
  // low REMW bits of the subtraction are sufficient.
  assign w_remShift = {r_rem, r_radicand[RADW-1 -: 2]};
  assign w_trial    = {2'b00, r_root, 2'b01};
  assign w_fits     = (w_remShift >= w_trial);
  assign w_diff     = w_remShift[REMW-1:0] - w_trial[REMW-1:0];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. An in-flight sample always runs to completion; enable
  // only matters for accepting new work in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = SQUARE;
        end
      end
      SQUARE: begin
        w_nextState = SQRT;
      end
      SQRT: begin
        if (r_iter == CNTW'(DATA_WIDTH - 1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, squaring, and the square-root iterations.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_re       <= '0;
      r_im       <= '0;
      r_radicand <= '0;
      r_root     <= '0;
      r_rem      <= '0;
      r_iter     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_re <= dataInRe;
            r_im <= dataInIm;
          end
        end
        SQUARE: begin
          r_radicand <= w_sumSq;
          r_root     <= '0;
          r_rem      <= '0;
          r_iter     <= '0;
        end
        SQRT: begin
          r_radicand <= r_radicand << 2;
          r_root     <= {r_root[DATA_WIDTH-2:0], w_fits};
          r_rem      <= w_fits ? w_diff : w_remShift[REMW-1:0];
          r_iter     <= r_iter + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output registers. dataOut holds its value between results and is only
  // cleared by reset or by sitting idle with the block disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataOut      <= '0;
      dataOutValid <= 1'b0;
    end else begin
      dataOutValid <= 1'b0;
      if (r_state == DONE) begin
        dataOut      <= r_root;
        dataOutValid <= 1'b1;
      end else if (r_state == IDLE && !enable) begin
        dataOut <= '0;
      end
    end
  end

endmodule

// File: tb/tb_envelope_detector.sv
// tb_envelope_detector
//   Scoreboard bench for envelope_detector. The driver pushes the expected
//   magnitude when a transfer is seen; a separate monitor pops and compares
//   whenever dataOutValid pulses, and also checks the accept-to-output
//   latency.
module tb_envelope_detector;

  localparam int DW = 18;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic signed [DW-1:0] dataInRe;
  logic signed [DW-1:0] dataInIm;
  logic                 dataInValid;
  logic                 dataInReady;
  logic        [DW-1:0] dataOut;
  logic                 dataOutValid;

  int checks;
  int errors;
  int negCount;
  int outCount;

  longint expQ[$];
  int     accQ[$];

  envelope_detector #(.DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .dataInRe    (dataInRe),
    .dataInIm    (dataInIm),
    .dataInValid (dataInValid),
    .dataInReady (dataInReady),
    .dataOut     (dataOut),
    .dataOutValid(dataOutValid)
  );

  // 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference magnitude built greedily from the top bit down.
  function automatic longint isqrtModel(input longint x);
    longint r;
    longint t;
    r = 0;
    for (int b = DW - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // Present a sample (caller is just after a rising edge), wait for the
  // transfer, queue the expected result, then optionally drop valid.
  task automatic applyStimulus(input int re, input int im, input longint expected, input bit holdValid);
    bit accepted;
    dataInRe    = re[DW-1:0];
    dataInIm    = im[DW-1:0];
    dataInValid = 1'b1;
    accepted    = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clock);
      if (dataInReady) begin
        accepted = 1'b1;
        expQ.push_back(expected);
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got no transfer, expected one for (%0d,%0d)", re, im);
    end
    @(posedge clock);
    #1;
    if (!holdValid) dataInValid = 1'b0;
  endtask

  // Wait until every queued result has come out, bounded.
  task automatic waitDrain();
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 200) begin
      @(posedge clock);
      budget++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d pending, expected 0", expQ.size());
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: inputs change just after rising edges, so the falling edge sees
  // stable handshakes and outputs. A transfer seen at one falling edge should
  // produce its output 21 falling edges later.
  always @(negedge clock) begin
    longint e;
    int     a;
    negCount++;
    if (dataInValid && dataInReady) accQ.push_back(negCount);
    if (dataOutValid) begin
      outCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedOutput: got %0d, expected no output", dataOut);
      end else begin
        e = expQ.pop_front();
        checkOutput("magnitude", longint'(dataOut), e);
        if (accQ.size() != 0) begin
          a = accQ.pop_front();
          checkOutput("latency", longint'(negCount - a), 21);
        end
      end
    end
  end

  initial begin
    logic signed [DW-1:0] rr;
    logic signed [DW-1:0] ri;
    longint               sum;
    int                   outsBefore;

    checks      = 0;
    errors      = 0;
    negCount    = 0;
    outCount    = 0;
    reset       = 1'b1;
    enable      = 1'b1;
    dataInRe    = '0;
    dataInIm    = '0;
    dataInValid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clock);
    checkOutput("resetDataOut", longint'(dataOut), 0);
    checkOutput("resetValid", longint'(dataOutValid), 0);
    checkOutput("resetReady", longint'(dataInReady), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("readyAfterReset", longint'(dataInReady), 1);
    @(posedge clock);
    #1;

    // Directed vectors.
    applyStimulus(3, 4, 5, 1'b0);
    applyStimulus(-131072, -131072, 185363, 1'b0);
    applyStimulus(131071, 0, 131071, 1'b0);
    applyStimulus(0, 0, 0, 1'b0);
    applyStimulus(1, 1, 1, 1'b0);
    applyStimulus(131071, 131071, 185362, 1'b0);
    applyStimulus(-7, 24, 25, 1'b0);
    waitDrain();

    // Valid held across two samples: second waits for the first to finish.
    outsBefore = outCount;
    applyStimulus(3, 4, 5, 1'b1);
    @(negedge clock);
    checkOutput("readyBusy", longint'(dataInReady), 0);
    @(posedge clock);
    #1;
    applyStimulus(6, 8, 10, 1'b0);
    waitDrain();
    checkOutput("heldOutputs", longint'(outCount - outsBefore), 2);

    // Reset in the middle of the square root: no result comes out.
    applyStimulus(3, 4, 5, 1'b0);
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midResetDataOut", longint'(dataOut), 0);
    checkOutput("midResetValid", longint'(dataOutValid), 0);
    expQ.delete();
    accQ.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    outsBefore = outCount;
    repeat (25) @(posedge clock);
    #1;
    checkOutput("noPulseAfterReset", longint'(outCount - outsBefore), 0);
    applyStimulus(5, 12, 13, 1'b0);
    waitDrain();

    // Enable dropped mid-computation: in-flight sample still completes.
    applyStimulus(8, 15, 17, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    enable = 1'b0;
    waitDrain();
    dataInRe    = 18'sd3;
    dataInIm    = 18'sd4;
    dataInValid = 1'b1;
    outsBefore  = outCount;
    repeat (3) @(negedge clock);
    checkOutput("disabledDataOut", longint'(dataOut), 0);
    checkOutput("disabledReady", longint'(dataInReady), 0);
    repeat (30) @(posedge clock);
    #1;
    checkOutput("disabledNoOutput", longint'(outCount - outsBefore), 0);
    dataInValid = 1'b0;
    enable      = 1'b1;
    @(posedge clock);
    #1;

    // Random samples against the reference model.
    for (int n = 0; n < 300; n++) begin
      rr  = DW'($urandom());
      ri  = DW'($urandom());
      sum = longint'(rr) * longint'(rr) + longint'(ri) * longint'(ri);
      applyStimulus(int'(rr), int'(ri), isqrtModel(sum), 1'b0);
    end
    waitDrain();

    checkOutput("scoreboardEmpty", longint'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
